interval_timer: RTL

Parametrised, programmable-threshold successor to the fixed short/long interval timer used by the traffic-light controller. It provides a WIDTH-bit up-counter with:
- start, stop and pause control;
- runtime-loadable short and long thresholds;
- saturation instead of wrap-around;
- optional single-cycle edge pulses on each threshold crossing.

It sits between the light-sequencing FSM (which drives ST/Stop/Ld) and the phase-duration logic (which consumes TS/TL).

---
 rtl/interval_timer_if.sv | 28 ++
 rtl/interval_timer.sv | 83 ++++++++
 2 files changed

// File: rtl/interval_timer_if.sv
// Control/status bundle between the light-sequencing FSM (master) and interval_timer (slave).
interface interval_timer_if #(
    parameter int WIDTH = 8
);
    logic             ST;
    logic             Stop;
    logic             En;
    logic             Ld;
    logic [WIDTH-1:0] TsVal;
    logic [WIDTH-1:0] TlVal;
    logic [WIDTH-1:0] Value;
    logic             Busy;
    logic             TS;
    logic             TL;
    logic             Sat;
    logic             TSP;
    logic             TLP;

    modport master (
        output ST, Stop, En, Ld, TsVal, TlVal,
        input  Value, Busy, TS, TL, Sat, TSP, TLP
    );

    modport slave (
        input  ST, Stop, En, Ld, TsVal, TlVal,
        output Value, Busy, TS, TL, Sat, TSP, TLP
    );
endinterface

// File: rtl/interval_timer.sv
// Saturating interval timer with loadable short/long thresholds.
// Define INTERVAL_TIMER_PULSE_EN to build the TSP/TLP rising-edge pulse logic.
module interval_timer #(
    parameter int WIDTH   = 8,
    parameter int TS_INIT = 4,
    parameter int TL_INIT = 14
) (
    input  logic              Clk,
    input  logic              Rst,
    interval_timer_if.slave   tmr
);
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] thr_s;
    logic [WIDTH-1:0] thr_l;
    logic             busy;
    logic             ts;
    logic             tl;

    // En is resampled every active edge, so the edge that resumes from HOLD also counts.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
            count <= '0;
            thr_s <= WIDTH'(TS_INIT);
            thr_l <= WIDTH'(TL_INIT);
        end else begin
            if (tmr.Ld) begin
                thr_s <= tmr.TsVal;
                thr_l <= tmr.TlVal;
            end
            if (tmr.ST) begin
                state <= RUN;
                count <= '0;
            end else if (tmr.Stop) begin
                state <= IDLE;
                count <= '0;
            end else if (state != IDLE) begin
                state <= tmr.En ? RUN : HOLD;
                if (tmr.En && (count != '1)) begin
                    count <= count + WIDTH'(1);
                end
            end
        end
    end

    assign busy = (state != IDLE);
    assign ts   = busy && (count >= thr_s);
    assign tl   = busy && (count >= thr_l);

    assign tmr.Value = count;
    assign tmr.Busy  = busy;
    assign tmr.TS    = ts;
    assign tmr.TL    = tl;
    assign tmr.Sat   = busy && (count == '1);

`ifdef INTERVAL_TIMER_PULSE_EN
    logic ts_q;
    logic tl_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            ts_q <= 1'b0;
            tl_q <= 1'b0;
        end else begin
            ts_q <= ts;
            tl_q <= tl;
        end
    end

    assign tmr.TSP = ts & ~ts_q;
    assign tmr.TLP = tl & ~tl_q;
`else
    assign tmr.TSP = 1'b0;
    assign tmr.TLP = 1'b0;
`endif
endmodule
